// File: rtl/dmem_latency_ctrl_pkg.sv
// Shared types and constants for the data-memory latency controller.
package dmem_latency_ctrl_pkg;

  typedef logic [31:0] word32_t;

  localparam int unsigned DMEM_MAX_LATENCY = 15;
  localparam int unsigned DMEM_CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  // Counter preload for a given latency, clamped to the legal 1..15 window.
  function automatic logic [DMEM_CNT_W-1:0] dmem_cnt_load(input int unsigned latency);
    if (latency == 0) begin
      return '0;
    end else if (latency > DMEM_MAX_LATENCY) begin
      return DMEM_CNT_W'(DMEM_MAX_LATENCY - 1);
    end else begin
      return DMEM_CNT_W'(latency - 1);
    end
  endfunction

endpackage

// File: rtl/dmem_latency_ctrl_if.sv
// Request/response bundle between the LSU read/write unit and the data-memory controller.
interface dmem_latency_ctrl_if
  import dmem_latency_ctrl_pkg::*;
();

  logic    dmem_read_i;
  logic    dmem_write_i;
  word32_t dmem_addr_i;
  word32_t dmem_data_i;
  word32_t dmem_rd_data_o;
  logic    dmem_done_o;
  logic    busy_o;
  logic    misaligned_o;

  modport slave (
    input  dmem_read_i,
    input  dmem_write_i,
    input  dmem_addr_i,
    input  dmem_data_i,
    output dmem_rd_data_o,
    output dmem_done_o,
    output busy_o,
    output misaligned_o
  );

  modport master (
    output dmem_read_i,
    output dmem_write_i,
    output dmem_addr_i,
    output dmem_data_i,
    input  dmem_rd_data_o,
    input  dmem_done_o,
    input  busy_o,
    input  misaligned_o
  );

endinterface

// File: rtl/dmem_latency_ctrl_sram_array.sv
// Synchronous single-port word RAM with a registered read port and no reset.
module dmem_latency_ctrl_sram_array
  import dmem_latency_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_POW2 = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  en_i,
  input  logic [DEPTH_POW2-1:0] idx_i,
  input  word32_t               wdata_i,
  output word32_t               rdata_o
);

  word32_t r_mem [2**DEPTH_POW2];
  word32_t r_rdata;

  // Read port only updates on reads so the last load value is held across writes.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        r_mem[idx_i] <= wdata_i;
      end else begin
        r_rdata <= r_mem[idx_i];
      end
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/dmem_latency_ctrl.sv
// Data-memory controller: latches one LSU request, waits a fixed latency, then
// commits the SRAM access and pulses done for one cycle.
module dmem_latency_ctrl
  import dmem_latency_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_POW2 = 10,
  parameter int unsigned LATENCY    = 3
) (
  input logic                 clk_i,
  input logic                 reset_ni,
  dmem_latency_ctrl_if.slave  bus
);

  localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = dmem_cnt_load(LATENCY);

  dmem_state_t           r_state;
  dmem_state_t           w_state_nxt;
  logic [DMEM_CNT_W-1:0] r_cnt;
  logic [DMEM_CNT_W-1:0] w_cnt_nxt;
  logic                  w_accept;
  logic                  w_commit;

  logic                  r_is_write;
  logic [DEPTH_POW2-1:0] r_idx;
  word32_t               r_wdata;
  logic                  r_misaligned;
  logic                  r_rd_valid;
  word32_t               w_sram_rdata;
  logic                  w_unused_addr_hi;

  assign w_unused_addr_hi = ^bus.dmem_addr_i[31:DEPTH_POW2+2];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.dmem_read_i || bus.dmem_write_i) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_commit    = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_is_write   <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_misaligned <= 1'b0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        // Write wins when both requests are raised together.
        r_is_write <= bus.dmem_write_i;
        r_idx      <= bus.dmem_addr_i[DEPTH_POW2+1:2];
        r_wdata    <= bus.dmem_data_i;
        if (bus.dmem_addr_i[1:0] != 2'b00) begin
          r_misaligned <= 1'b1;
        end
      end
      if (w_commit && !r_is_write) begin
        r_rd_valid <= 1'b1;
      end
    end
  end

  dmem_latency_ctrl_sram_array #(
    .DEPTH_POW2 (DEPTH_POW2)
  ) u_sram (
    .clk_i   (clk_i),
    .we_i    (w_commit && r_is_write),
    .en_i    (w_commit),
    .idx_i   (r_idx),
    .wdata_i (r_wdata),
    .rdata_o (w_sram_rdata)
  );

  // The RAM read register has no reset; gate it so load data reads zero until a read lands.
  assign bus.dmem_rd_data_o = r_rd_valid ? w_sram_rdata : '0;
  assign bus.dmem_done_o    = (r_state == RESP);
  assign bus.busy_o         = (r_state != IDLE);
  assign bus.misaligned_o   = r_misaligned;

endmodule

// File: tb/tb_dmem_latency_ctrl.sv
// Self-checking bench: table-driven accesses on a LATENCY=3 instance, corner sequences,
// and a LATENCY=1 back-to-back run, with a done-time/data scoreboard per instance.
module tb_dmem_latency_ctrl;
  import dmem_latency_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_latency_ctrl_if bus3 ();
  dmem_latency_ctrl_if bus1 ();

  dmem_latency_ctrl #(.DEPTH_POW2(10), .LATENCY(3)) dut3 (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus3)
  );

  dmem_latency_ctrl #(.DEPTH_POW2(10), .LATENCY(1)) dut1 (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus1)
  );

  typedef struct {
    int      cyc;
    word32_t data;
  } exp_t;

  typedef struct {
    logic    rd;
    logic    wr;
    word32_t addr;
    word32_t data;
    word32_t exp_rd;
    logic    exp_mis;
  } vec_t;

  exp_t q3[$];
  exp_t q1[$];
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not match expectation (cycle %0d)", name, cyc);
  endtask

  // Scoreboards: every done must match the next queued completion cycle and load data.
  always @(negedge clk) begin
    if (bus3.dmem_done_o === 1'b1) begin
      if (q3.size() == 0) begin
        fail_now("lat3 unexpected done");
      end else begin
        exp_t e;
        e = q3.pop_front();
        check("lat3 done cycle", 32'(cyc), 32'(e.cyc));
        check("lat3 rd_data", bus3.dmem_rd_data_o, e.data);
      end
    end
    if (bus1.dmem_done_o === 1'b1) begin
      if (q1.size() == 0) begin
        fail_now("lat1 unexpected done");
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("lat1 done cycle", 32'(cyc), 32'(e.cyc));
        check("lat1 rd_data", bus1.dmem_rd_data_o, e.data);
      end
    end
  end

  task automatic acc3(input vec_t v);
    int   t;
    bit   seen;
    exp_t e;
    @(posedge clk);
    #1;
    bus3.dmem_read_i  = v.rd;
    bus3.dmem_write_i = v.wr;
    bus3.dmem_addr_i  = v.addr;
    bus3.dmem_data_i  = v.data;
    t = cyc;
    e.cyc  = t + 4;
    e.data = v.exp_rd;
    q3.push_back(e);
    @(negedge clk);
    check("lat3 idle busy", 32'(bus3.busy_o), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus3.dmem_done_o === 1'b1) seen = 1'b1;
      else check("lat3 wait busy", 32'(bus3.busy_o), 32'd1);
    end
    if (!seen) begin
      fail_now("lat3 done timeout");
    end else begin
      check("lat3 resp busy", 32'(bus3.busy_o), 32'd1);
      check("lat3 misaligned", 32'(bus3.misaligned_o), 32'(v.exp_mis));
    end
    @(posedge clk);
    #1;
    bus3.dmem_read_i  = 1'b0;
    bus3.dmem_write_i = 1'b0;
  endtask

  initial begin
    int      t;
    int      t0;
    word32_t last_rd1;
    exp_t    e;

    vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_1004, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'h0000_1234, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 32'h0000_1234, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'hA5A5_A5A5, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0055, 32'hA5A5_A5A5, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0055, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0001, 32'h0000_0055, 1'b1};

    rst_n = 1'b0;
    bus3.dmem_read_i = 1'b0; bus3.dmem_write_i = 1'b0;
    bus3.dmem_addr_i = '0;   bus3.dmem_data_i  = '0;
    bus1.dmem_read_i = 1'b0; bus1.dmem_write_i = 1'b0;
    bus1.dmem_addr_i = '0;   bus1.dmem_data_i  = '0;

    repeat (2) @(negedge clk);
    check("reset busy", 32'(bus3.busy_o), 32'd0);
    check("reset done", 32'(bus3.dmem_done_o), 32'd0);
    check("reset rd_data", bus3.dmem_rd_data_o, 32'd0);
    check("reset misaligned", 32'(bus3.misaligned_o), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) acc3(vecs[i]);

    // Read held across done: a second access starts in the intervening IDLE cycle.
    @(posedge clk);
    #1;
    bus3.dmem_read_i = 1'b1;
    bus3.dmem_addr_i = 32'h0000_0010;
    t = cyc;
    e.cyc = t + 4; e.data = 32'hA5A5_A5A5; q3.push_back(e);
    e.cyc = t + 9; e.data = 32'hA5A5_A5A5; q3.push_back(e);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cyc == t + 5) check("held idle busy", 32'(bus3.busy_o), 32'd0);
    end
    @(posedge clk);
    #1;
    bus3.dmem_read_i = 1'b0;

    // Reset in the second WAIT cycle of a write aborts it.
    @(posedge clk);
    #1;
    bus3.dmem_write_i = 1'b1;
    bus3.dmem_addr_i  = 32'h0000_0040;
    bus3.dmem_data_i  = 32'h0000_FFFF;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort busy", 32'(bus3.busy_o), 32'd0);
    check("abort done", 32'(bus3.dmem_done_o), 32'd0);
    check("abort rd_data", bus3.dmem_rd_data_o, 32'd0);
    check("abort misaligned", 32'(bus3.misaligned_o), 32'd0);
    bus3.dmem_write_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    acc3('{1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0001, 1'b0});

    // LATENCY=1: alternating write/read pairs issued back to back.
    last_rd1 = '0;
    @(posedge clk);
    #1;
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      word32_t a;
      word32_t d;
      a = 32'h0000_0100 + 32'(4 * (k / 2));
      d = 32'hC0DE_0000 + 32'(k * 32'h0101);
      bus1.dmem_addr_i = a;
      if (k % 2 == 0) begin
        bus1.dmem_write_i = 1'b1;
        bus1.dmem_read_i  = 1'b0;
        bus1.dmem_data_i  = d;
        e.data = last_rd1;
      end else begin
        bus1.dmem_write_i = 1'b0;
        bus1.dmem_read_i  = 1'b1;
        e.data   = 32'hC0DE_0000 + 32'((k - 1) * 32'h0101);
        last_rd1 = e.data;
      end
      e.cyc = t0 + 3 * k + 2;
      q1.push_back(e);
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        check("lat1 busy", 32'(bus1.busy_o), (j != 0) ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
      end
    end
    bus1.dmem_read_i  = 1'b0;
    bus1.dmem_write_i = 1'b0;

    repeat (4) @(negedge clk);
    check("lat3 pending", 32'(q3.size()), 32'd0);
    check("lat1 pending", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: bench did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
